// File: rtl/alu_iterative_if.sv
// Request/response bundle between the multi-cycle controller and the iterative ALU.
interface alu_iterative_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  busy_o, done_o, ALU_Result_o, Zero_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output busy_o, done_o, ALU_Result_o, Zero_o
  );
endinterface

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/LUI, bit-serial SLL/SRL,
// with a start/busy/done handshake toward the core's stall controller.
module alu_iterative #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_iterative_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1010;

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;      // 1 = shift right
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic [DATA_WIDTH-1:0]  alu_now;
  logic [DATA_WIDTH-1:0]  work_step;

  assign shamt    = bus.B_i[SHAMT_WIDTH-1:0];
  assign is_shift = (bus.ALU_Operation_i == OP_SLL) || (bus.ALU_Operation_i == OP_SRL);

  // Single-cycle result; shifts only reach this path with shamt=0, where result=A.
  always_comb begin
    alu_now = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:         alu_now = bus.A_i + bus.B_i;
      OP_SUB:         alu_now = bus.A_i - bus.B_i;
      OP_AND:         alu_now = bus.A_i & bus.B_i;
      OP_OR:          alu_now = bus.A_i | bus.B_i;
      OP_XOR:         alu_now = bus.A_i ^ bus.B_i;
      OP_LUI:         alu_now = bus.B_i;
      OP_SLL, OP_SRL: alu_now = bus.A_i;
      default:        alu_now = '0;
    endcase
  end

  assign work_step = dir_q ? {1'b0, work_q[DATA_WIDTH-1:1]}
                           : {work_q[DATA_WIDTH-2:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start_i) begin
          if (is_shift && (shamt != '0)) begin
            work_d  = bus.A_i;
            cnt_d   = shamt;
            dir_d   = (bus.ALU_Operation_i == OP_SRL);
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_now;
            zero_d   = (alu_now == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = work_step;
          zero_d   = (work_step == '0);
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy_o       = (state_q == ST_SHIFT);
  assign bus.done_o       = (state_q == ST_DONE);
  assign bus.ALU_Result_o = result_q;
  assign bus.Zero_o       = zero_q;
endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: expectations queued at issue, checked at done_o.
module tb_alu_iterative;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] res;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_iterative_if #(.DATA_WIDTH(DW)) bus();
  alu_iterative #(.DATA_WIDTH(DW), .SHAMT_WIDTH(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0100: return a & b;
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: return b;
      4'b1000: return a << b[4:0];
      4'b1010: return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [DW-1:0] b);
    if ((op == 4'b1000 || op == 4'b1010) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    bus.start_i = 1'b1;
    bus.ALU_Operation_i = op;
    bus.A_i = a;
    bus.B_i = b;
    e.res = model(op, a, b);
    e.lat = model_lat(op, b);
    sb.push_back(e);
  endtask

  // Waits (bounded) for done_o; start_i drops after the accepting edge.
  task automatic wait_done(input int max, output bit ok, output int lat);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      lat++;
      bus.start_i = 1'b0;
      if (bus.done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start_i = 1'b1;
    bus.ALU_Operation_i = 4'b0000;
    bus.A_i = 32'd1;
    bus.B_i = 32'd2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.ALU_Result_o !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.ALU_Result_o); end
      checks++; if (bus.Zero_o !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", bus.Zero_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    end
    reset = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", bus.busy_o, bus.done_o); end
  endtask

  task automatic test_add_sub();
    bit ok; int lat; exp_t e;
    issue(4'b0000, 32'd5, 32'd7);
    wait_done(5, ok, lat);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL add_lat got ok=%b lat=%0d want %0d", ok, lat, e.lat); end
    checks++; if (bus.ALU_Result_o !== e.res) begin errors++; $display("FAIL add_result got %h want %h", bus.ALU_Result_o, e.res); end
    // back-to-back: issued while in DONE
    issue(4'b0001, 32'd3, 32'd5);
    wait_done(5, ok, lat);
    e = sb.pop_front();
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL sub_b2b_lat got ok=%b lat=%0d want 1", ok, lat); end
    checks++; if (bus.ALU_Result_o !== 32'hFFFF_FFFE || bus.ALU_Result_o !== e.res) begin errors++; $display("FAIL sub_result got %h want fffffffe", bus.ALU_Result_o); end
    checks++; if (bus.Zero_o !== 1'b0) begin errors++; $display("FAIL sub_zero got %b want 0", bus.Zero_o); end
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", bus.done_o); end
  endtask

  task automatic test_zero_lui_logic();
    bit ok; int lat; exp_t e;
    logic [3:0]    ops [6] = '{4'b0001, 4'b0111, 4'b0100, 4'b0101, 4'b0110, 4'b0011};
    logic [DW-1:0] as  [6] = '{32'h1234, 32'h5555_5555, 32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555, 32'hFFFF_FFFF};
    logic [DW-1:0] bs  [6] = '{32'h1234, 32'hABCD_E000, 32'h0FF0_FF00, 32'h00F0_1000, 32'hFFFF_0000, 32'h1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(ops[i], as[i], bs[i]);
      wait_done(5, ok, lat);
      e = sb.pop_front();
      checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL op%0d_lat got ok=%b lat=%0d want %0d", i, ok, lat, e.lat); end
      checks++; if (bus.ALU_Result_o !== e.res) begin errors++; $display("FAIL op%0d_result got %h want %h", i, bus.ALU_Result_o, e.res); end
      checks++; if (bus.Zero_o !== (e.res == '0)) begin errors++; $display("FAIL op%0d_zero got %b want %b", i, bus.Zero_o, (e.res == '0)); end
    end
  endtask

  task automatic test_shift();
    bit ok; int lat; int busy_cnt; exp_t e;
    logic [3:0]    ops [4] = '{4'b1000, 4'b1010, 4'b1000, 4'b1010};
    logic [DW-1:0] as  [4] = '{32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'hC000_0003};
    logic [DW-1:0] bs  [4] = '{32'd31, 32'd4, 32'hFFFF_FFE0, 32'd31};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(ops[i], as[i], bs[i]);
      busy_cnt = 0;
      ok = 1'b0;
      lat = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        lat++;
        bus.start_i = 1'b0;
        if (bus.busy_o) busy_cnt++;
        if (bus.done_o) begin ok = 1'b1; break; end
      end
      e = sb.pop_front();
      checks++; if (!ok || lat != e.lat) begin errors++; $display("FAIL shift%0d_lat got ok=%b lat=%0d want %0d", i, ok, lat, e.lat); end
      checks++; if (busy_cnt != e.lat - 1) begin errors++; $display("FAIL shift%0d_busy got %0d want %0d", i, busy_cnt, e.lat - 1); end
      checks++; if (bus.ALU_Result_o !== e.res) begin errors++; $display("FAIL shift%0d_result got %h want %h", i, bus.ALU_Result_o, e.res); end
    end
  endtask

  task automatic test_handshake();
    int ndone = 0; int lat = 0; int cyc = 0;
    logic [DW-1:0] res = '0; logic [DW-1:0] held; exp_t e;
    bit stable = 1'b1;
    @(negedge clk);
    held = bus.ALU_Result_o;
    issue(4'b1000, 32'h0000_0003, 32'd10);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start_i = 1'b0;
      if (cyc == 3) begin
        bus.start_i = 1'b1;
        bus.ALU_Operation_i = 4'b0000;
        bus.A_i = 32'h0000_FFFF;
        bus.B_i = 32'd1;
      end
      if (cyc == 4) bus.start_i = 1'b0;
      if (bus.busy_o && bus.ALU_Result_o !== held) stable = 1'b0;
      if (bus.done_o) begin
        ndone++;
        if (ndone == 1) begin lat = cyc; res = bus.ALU_Result_o; end
      end
    end
    e = sb.pop_front();
    checks++; if (ndone != 1) begin errors++; $display("FAIL hs_done_count got %0d want 1", ndone); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL hs_lat got %0d want %0d", lat, e.lat); end
    checks++; if (res !== e.res) begin errors++; $display("FAIL hs_result got %h want %h", res, e.res); end
    checks++; if (!stable) begin errors++; $display("FAIL hs_result_stable got changed want held %h", held); end
  endtask

  task automatic test_reset_mid_shift();
    bit ok; int lat; int ndone = 0; exp_t e;
    @(negedge clk);
    issue(4'b1010, 32'hF000_0000, 32'd20);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      if (bus.done_o) ndone++;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin errors++; $display("FAIL mid_reset_state got busy=%b done=%b want 0 0", bus.busy_o, bus.done_o); end
    checks++; if (bus.ALU_Result_o !== 32'd0 || bus.Zero_o !== 1'b1) begin errors++; $display("FAIL mid_reset_result got %h z=%b want 0 z=1", bus.ALU_Result_o, bus.Zero_o); end
    reset = 1'b1;
    void'(sb.pop_front());
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL mid_reset_no_done got %0d want 0", ndone); end
    issue(4'b0000, 32'hFFFF_FFFF, 32'd2);
    wait_done(5, ok, lat);
    e = sb.pop_front();
    checks++; if (!ok || lat != e.lat || bus.ALU_Result_o !== e.res) begin errors++; $display("FAIL after_reset_op got ok=%b lat=%0d res=%h want lat=%0d res=%h", ok, lat, bus.ALU_Result_o, e.lat, e.res); end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.ALU_Operation_i = 4'b0000;
    bus.A_i = '0;
    bus.B_i = '0;
    test_reset();
    test_add_sub();
    test_zero_lui_logic();
    test_shift();
    test_handshake();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
